instruction_fetch_unit: RTL

- Fetch stage directly upstream of Instruction_Memory.
- Owns the 64-bit program counter and drives Inst_Address into Instruction_Memory.
- Captures the returned 32-bit Instruction into an IF/ID pipeline register for the decode stage.
- Handles decode-stage stalls, taken-branch redirects (flush), misaligned/out-of-range targets, and end-of-program halt.

---
 rtl/instruction_fetch_unit.sv | 124 ++++++++++++
 1 files changed

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the program counter, addresses instruction memory and
// fills the IF/ID pipeline register. Handles decode stalls, taken-branch
// redirects, bad branch targets and end-of-program halt.
module instruction_fetch_unit #(
  parameter logic [63:0] RESET_PC   = 64'd0,
  parameter logic [63:0] IMEM_BYTES = 64'd16,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall,
  input  logic        Branch_Taken,
  input  logic [63:0] Branch_Target,
  input  logic [31:0] Instruction,
  output logic [63:0] Inst_Address,
  output logic [63:0] IF_ID_PC,
  output logic [31:0] IF_ID_Instruction,
  output logic        IF_ID_Valid,
  output logic        Halted,
  output logic        Misaligned
);

  localparam logic [1:0] START = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] HALT  = 2'd2;

  logic [1:0]  r_state;
  logic [63:0] r_pc;
  logic [63:0] r_if_pc;
  logic [31:0] r_if_inst;
  logic        r_if_valid;
  logic        r_halted;
  logic        r_misaligned;

  logic        w_tgt_misaligned;
  logic        w_tgt_ok;
  logic [63:0] w_pc_plus4;
  logic        w_last_word;

  // Classify the branch target and the sequential successor of the PC.
  always_comb begin
    w_tgt_misaligned = (Branch_Target[1:0] != 2'b00);
    w_tgt_ok         = !w_tgt_misaligned && (Branch_Target < IMEM_BYTES);
    w_pc_plus4       = r_pc + 64'd4;
    w_last_word      = !(w_pc_plus4 < IMEM_BYTES);
  end

  // PC, IF/ID register and fetch FSM; branch beats stall beats sequential fetch.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= START;
      r_pc         <= RESET_PC;
      r_if_pc      <= 64'd0;
      r_if_inst    <= NOP_INST;
      r_if_valid   <= 1'b0;
      r_halted     <= 1'b0;
      r_misaligned <= 1'b0;
    end else begin
      case (r_state)
        START: begin
          r_if_inst  <= NOP_INST;
          r_if_valid <= 1'b0;
          r_state    <= RUN;
        end
        RUN: begin
          if (Branch_Taken) begin
            // Wrong-path instruction is flushed whether or not the target is usable.
            r_if_inst  <= NOP_INST;
            r_if_valid <= 1'b0;
            if (w_tgt_ok) begin
              r_pc <= Branch_Target;
            end else begin
              r_halted <= 1'b1;
              r_state  <= HALT;
              if (w_tgt_misaligned) r_misaligned <= 1'b1;
            end
          end else if (!Stall) begin
            r_if_pc    <= r_pc;
            r_if_inst  <= Instruction;
            r_if_valid <= 1'b1;
            if (w_last_word) begin
              // PC parks on the last in-range word.
              r_halted <= 1'b1;
              r_state  <= HALT;
            end else begin
              r_pc <= w_pc_plus4;
            end
          end
        end
        HALT: begin
          if (Branch_Taken) begin
            r_if_inst  <= NOP_INST;
            r_if_valid <= 1'b0;
            if (w_tgt_ok) begin
              r_pc     <= Branch_Target;
              r_halted <= 1'b0;
              r_state  <= RUN;
            end else if (w_tgt_misaligned) begin
              r_misaligned <= 1'b1;
            end
          end else if (!Stall) begin
            // Drain: only once decode accepts does the last real instruction leave.
            r_if_inst  <= NOP_INST;
            r_if_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= START;
        end
      endcase
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    Inst_Address      = r_pc;
    IF_ID_PC          = r_if_pc;
    IF_ID_Instruction = r_if_inst;
    IF_ID_Valid       = r_if_valid;
    Halted            = r_halted;
    Misaligned        = r_misaligned;
  end

endmodule
